// File: rtl/periodic_test_harness.sv
// periodic_test_harness
//   Issues a one-cycle start pulse every sampled period, hands latched
//   operands to NUM_CH downstream units, collects one result per channel
//   within TIMEOUT cycles and exposes the captures through a registered
//   readout port together with freshness, timeout and missing-channel status.
//
// Ports
//   clk_in, rst_in     clock, asynchronous active-high reset
//   enable_in          run periodic transactions while high
//   period_in          cycles between start pulses (0 behaves as 1)
//   op_a_in, op_b_in   operands, latched on start
//   res_valid_in       per-channel result-valid pulses
//   res_data_in        packed results, channel i at [i*WIDTH +: WIDTH]
//   sel_in             readout channel select
//   clr_in             clears timeout_out / missing_out
//   start_out          one-cycle start pulse
//   op_a_out, op_b_out operands held from the last start
//   rd_data_out        registered capture of channel sel_in
//   rd_fresh_out       selected channel captured in last completed transaction
//   busy_out           transaction in flight (ISSUE or WAIT)
//   timeout_out        sticky timeout flag
//   missing_out        channels absent in the latest timed-out transaction
//   run_count_out      completed transactions, saturating
module periodic_test_harness #(
  parameter int WIDTH    = 32,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 14,
  parameter int TIMEOUT  = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      enable_in,
  input  logic [PERIOD_W-1:0]       period_in,
  input  logic [WIDTH-1:0]          op_a_in,
  input  logic [WIDTH-1:0]          op_b_in,
  input  logic [NUM_CH-1:0]         res_valid_in,
  input  logic [NUM_CH*WIDTH-1:0]   res_data_in,
  input  logic [$clog2(NUM_CH)-1:0] sel_in,
  input  logic                      clr_in,
  output logic                      start_out,
  output logic [WIDTH-1:0]          op_a_out,
  output logic [WIDTH-1:0]          op_b_out,
  output logic [WIDTH-1:0]          rd_data_out,
  output logic                      rd_fresh_out,
  output logic                      busy_out,
  output logic                      timeout_out,
  output logic [NUM_CH-1:0]         missing_out,
  output logic [15:0]               run_count_out
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_ISSUE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                load_period;
  logic [NUM_CH-1:0]   got_q, got_nxt;
  logic [NUM_CH-1:0]   fresh_q;
  logic [NUM_CH-1:0]   missing_q;
  logic [WIDTH-1:0]    cap_q [NUM_CH];
  logic [WIDTH-1:0]    op_a_q, op_b_q;
  logic [WIDTH-1:0]    rd_data_q;
  logic                rd_fresh_q;
  logic                timeout_q;
  logic [15:0]         run_q;
  logic                in_wait, done_ok, done_to;

  // Completion is judged on the mask including this cycle's arrivals, so a
  // last result landing on the final wait cycle still counts as success.
  assign in_wait = (state_q == S_WAIT);
  assign got_nxt = got_q | res_valid_in;
  assign done_ok = in_wait && (&got_nxt);
  assign done_to = in_wait && !(&got_nxt) && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    load_period = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable_in) begin
          state_d     = S_COUNT;
          cnt_d       = '0;
          load_period = 1'b1;
        end
      end
      S_COUNT: begin
        if (!enable_in) begin
          state_d = S_IDLE;
        end else if (cnt_q == period_q - PERIOD_W'(1)) begin
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        // Dropping enable never aborts an in-flight transaction; it only
        // decides where we go once the transaction completes.
        if (done_ok || done_to) begin
          if (enable_in) begin
            state_d     = S_COUNT;
            cnt_d       = '0;
            load_period = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      period_q  <= PERIOD_W'(1);
      cnt_q     <= '0;
      wait_q    <= '0;
      got_q     <= '0;
      fresh_q   <= '0;
      missing_q <= '0;
      timeout_q <= 1'b0;
      run_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      if (load_period) begin
        period_q <= (period_in == '0) ? PERIOD_W'(1) : period_in;
      end
      if (state_q == S_ISSUE) begin
        op_a_q <= op_a_in;
        op_b_q <= op_b_in;
        got_q  <= '0;
      end else if (in_wait) begin
        got_q <= got_nxt;
      end
      if (done_ok) begin
        fresh_q <= '1;
      end else if (done_to) begin
        fresh_q <= got_nxt;
      end
      if ((done_ok || done_to) && (run_q != 16'hFFFF)) begin
        run_q <= run_q + 16'd1;
      end
      // Clear first, then a same-cycle timeout overrides it.
      if (clr_in) begin
        timeout_q <= 1'b0;
        missing_q <= '0;
      end
      if (done_to) begin
        timeout_q <= 1'b1;
        missing_q <= ~got_nxt;
      end
    end
  end

  // NOTE: the capture bank is reset even though it is storage, because its
  // contents are directly observable on rd_data_out after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CH; i++) cap_q[i] <= '0;
    end else if (in_wait) begin
      // First pulse per channel wins; repeats within a transaction are dropped.
      for (int i = 0; i < NUM_CH; i++) begin
        if (res_valid_in[i] && !got_q[i]) cap_q[i] <= res_data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Registered readout; out-of-range selects (non power-of-two NUM_CH) read 0.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_data_q  <= '0;
      rd_fresh_q <= 1'b0;
    end else if (32'(sel_in) < NUM_CH) begin
      rd_data_q  <= cap_q[sel_in];
      rd_fresh_q <= fresh_q[sel_in];
    end else begin
      rd_data_q  <= '0;
      rd_fresh_q <= 1'b0;
    end
  end

  assign start_out     = (state_q == S_ISSUE);
  assign busy_out      = (state_q == S_ISSUE) || in_wait;
  assign op_a_out      = op_a_q;
  assign op_b_out      = op_b_q;
  assign rd_data_out   = rd_data_q;
  assign rd_fresh_out  = rd_fresh_q;
  assign timeout_out   = timeout_q;
  assign missing_out   = missing_q;
  assign run_count_out = run_q;

endmodule

// File: tb/tb_periodic_test_harness.sv
module tb_periodic_test_harness;

  localparam int WIDTH    = 32;
  localparam int NUM_CH   = 2;
  localparam int PERIOD_W = 14;
  localparam int TIMEOUT  = 64;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    enable_in;
  logic [PERIOD_W-1:0]     period_in;
  logic [WIDTH-1:0]        op_a_in, op_b_in;
  logic [NUM_CH-1:0]       res_valid_in;
  logic [NUM_CH*WIDTH-1:0] res_data_in;
  logic [0:0]              sel_in;
  logic                    clr_in;
  logic                    start_out;
  logic [WIDTH-1:0]        op_a_out, op_b_out, rd_data_out;
  logic                    rd_fresh_out, busy_out, timeout_out;
  logic [NUM_CH-1:0]       missing_out;
  logic [15:0]             run_count_out;

  periodic_test_harness #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in), .period_in(period_in),
    .op_a_in(op_a_in), .op_b_in(op_b_in), .res_valid_in(res_valid_in),
    .res_data_in(res_data_in), .sel_in(sel_in), .clr_in(clr_in),
    .start_out(start_out), .op_a_out(op_a_out), .op_b_out(op_b_out),
    .rd_data_out(rd_data_out), .rd_fresh_out(rd_fresh_out), .busy_out(busy_out),
    .timeout_out(timeout_out), .missing_out(missing_out), .run_count_out(run_count_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [0:0]       sel;
    logic [WIDTH-1:0] data;
    logic             fresh;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_start(input int max_cyc, output int n);
    n = 0;
    while (!start_out && n < max_cyc) begin
      tick();
      n++;
    end
    check("start_seen", start_out, 1);
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    logic seen;
    seen = 1'b0;
    repeat (ncyc) begin
      tick();
      if (start_out) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  task automatic push_exp(input logic [0:0] sel, input logic [WIDTH-1:0] data, input logic fresh);
    exp_t e;
    e.sel = sel; e.data = data; e.fresh = fresh;
    sb.push_back(e);
  endtask

  // Pop each expected capture, select its channel and compare the readout.
  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sel_in = e.sel;
      tick();
      check($sformatf("rd_data_ch%0d", e.sel), rd_data_out, e.data);
      check($sformatf("rd_fresh_ch%0d", e.sel), rd_fresh_out, e.fresh);
    end
  endtask

  initial begin
    int n, n2, s_prev;
    rst_in = 1'b1; enable_in = 1'b0; period_in = '0; op_a_in = '0; op_b_in = '0;
    res_valid_in = '0; res_data_in = '0; sel_in = '0; clr_in = 1'b0;
    repeat (3) tick();

    check("rst_start", start_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_timeout", timeout_out, 0);
    check("rst_missing", missing_out, 0);
    check("rst_run", run_count_out, 0);
    check("rst_op_a", op_a_out, 0);
    check("rst_op_b", op_b_out, 0);
    check("rst_rd_data", rd_data_out, 0);
    check("rst_rd_fresh", rd_fresh_out, 0);

    // Transaction 1: period 10, both channels answer on WAIT cycle 3.
    period_in = 14'd10; enable_in = 1'b1; rst_in = 1'b0;
    op_a_in = 32'h1234_5678; op_b_in = 32'h9ABC_DEF0;
    wait_start(40, n);
    check("first_start_not_early", (n >= 11), 1);
    s_prev = cyc;
    tick();
    check("start_width", start_out, 0);
    check("op_a_latched", op_a_out, 32'h1234_5678);
    check("op_b_latched", op_b_out, 32'h9ABC_DEF0);
    check("busy_wait", busy_out, 1);
    op_a_in = 32'hFFFF_0000;
    tick(); tick();
    res_valid_in = 2'b11; res_data_in = {32'h0000_0007, 32'h0000_0064};
    push_exp(1'b0, 32'h64, 1'b1);
    push_exp(1'b1, 32'h07, 1'b1);
    tick();
    res_valid_in = '0;
    check("t1_busy_done", busy_out, 0);
    check("t1_run", run_count_out, 1);
    check("t1_timeout", timeout_out, 0);
    check("op_a_stable", op_a_out, 32'h1234_5678);
    drain_sb();

    // Transaction 2: channel 1 never answers -> timeout after 64 WAIT cycles.
    wait_start(40, n);
    check("spacing_p10_w3", cyc - s_prev, 14);
    tick(); tick();
    res_valid_in = 2'b01; res_data_in = {32'h0000_DEAD, 32'h0000_00AA};
    push_exp(1'b0, 32'hAA, 1'b1);
    push_exp(1'b1, 32'h07, 1'b0);
    tick();
    res_valid_in = '0;
    repeat (61) tick();
    check("t2_busy_w64", busy_out, 1);
    check("t2_timeout_pre", timeout_out, 0);
    tick();
    check("t2_timeout", timeout_out, 1);
    check("t2_missing", missing_out, 2'b10);
    check("t2_run", run_count_out, 2);
    check("t2_busy_done", busy_out, 0);
    enable_in = 1'b0;
    drain_sb();
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check("clr_timeout", timeout_out, 0);
    check("clr_missing", missing_out, 0);
    expect_quiet("no_start_after_count_drop", 30);

    // Transaction 3: ch0 pulses twice, ch1 arrives on the last WAIT cycle,
    // and enable drops in the same cycle.
    period_in = 14'd3; enable_in = 1'b1;
    wait_start(20, n);
    check("start_latency_p3", n, 4);
    tick();
    res_valid_in = 2'b01; res_data_in = {32'h0, 32'h0000_0011};
    tick();
    res_data_in = {32'h0, 32'h0000_0022};
    tick();
    res_valid_in = '0;
    repeat (61) tick();
    check("t3_busy_w64", busy_out, 1);
    res_valid_in = 2'b10; res_data_in = {32'h0000_0033, 32'h0000_0044};
    enable_in = 1'b0;
    push_exp(1'b0, 32'h11, 1'b1);
    push_exp(1'b1, 32'h33, 1'b1);
    tick();
    res_valid_in = '0;
    check("t3_busy_done", busy_out, 0);
    check("t3_timeout", timeout_out, 0);
    check("t3_missing", missing_out, 0);
    check("t3_run", run_count_out, 3);
    drain_sb();
    expect_quiet("no_start_after_wait_drop", 20);

    // Transaction 4: period 0 behaves as 1.
    period_in = '0; enable_in = 1'b1;
    wait_start(10, n);
    check("start_latency_p0", n, 2);
    s_prev = cyc;
    tick();
    res_valid_in = 2'b11; res_data_in = {32'h0000_00A5, 32'h0000_005A};
    push_exp(1'b0, 32'h5A, 1'b1);
    push_exp(1'b1, 32'hA5, 1'b1);
    tick();
    res_valid_in = '0;
    check("t4_run", run_count_out, 4);
    wait_start(5, n);
    check("spacing_p0_w1", cyc - s_prev, 3);

    // Transaction 5: read back t4 while in WAIT, capture ch0, then reset mid-WAIT.
    drain_sb();
    res_valid_in = 2'b01; res_data_in = {32'h0, 32'h0000_0077};
    tick();
    res_valid_in = '0;
    tick();
    check("t5_busy_before_rst", busy_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check("arst_start", start_out, 0);
    check("arst_busy", busy_out, 0);
    check("arst_run", run_count_out, 0);
    check("arst_op_a", op_a_out, 0);
    check("arst_rd_data", rd_data_out, 0);
    check("arst_rd_fresh", rd_fresh_out, 0);
    check("arst_timeout", timeout_out, 0);
    check("arst_missing", missing_out, 0);
    period_in = 14'd5; sel_in = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    check("post_rst_no_pulse", start_out, 0);
    check("post_rst_cap0", rd_data_out, 0);
    check("post_rst_fresh0", rd_fresh_out, 0);
    wait_start(20, n2);
    check("rst_start_not_early", (n2 + 1 >= 6), 1);

    enable_in = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
